cla_bist: RTL

Built-in self-test sequencer for the 4-bit carry-lookahead adder group on the sum board. It drives the adder's operand side (`a`, `b`, `c_in`) through all 512 input combinations and samples the adder's response (`s`, `g_out`, `p_out`). It compares each response against an internal golden model and reports pass/fail, the error count and the first failing vector. It sits between the board's start button logic and the `cla_4` instance, replacing manual switch stimulus.

---
 rtl/cla_bist_pkg.sv | 16 +
 rtl/cla_bist_if.sv | 28 ++
 rtl/cla_bist_ref.sv | 21 ++
 rtl/cla_bist.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/cla_bist_pkg.sv
// rtl/cla_bist_pkg.sv - shared types and widths for the cla_4 BIST sequencer.
package cla_bist_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int             VEC_W    = 9;
  localparam logic [VEC_W-1:0] LAST_VEC = 9'd511;
  localparam int             ERR_W    = 10;
  localparam int             CNT_W    = 4;

endpackage

// File: rtl/cla_bist_if.sv
// rtl/cla_bist_if.sv - operand/response and status bundle between the BIST and the adder side.
interface cla_bist_if;

  logic                           start;
  logic [3:0]                     a;
  logic [3:0]                     b;
  logic                           c_in;
  logic [3:0]                     s;
  logic                           g_out;
  logic                           p_out;
  logic                           busy;
  logic                           done;
  logic                           pass;
  logic [cla_bist_pkg::ERR_W-1:0] err_cnt;
  logic [cla_bist_pkg::VEC_W-1:0] fail_vec;

  // master is the BIST sequencer, slave is the adder plus start logic
  modport master (
    input  start, s, g_out, p_out,
    output a, b, c_in, busy, done, pass, err_cnt, fail_vec
  );

  modport slave (
    output start, s, g_out, p_out,
    input  a, b, c_in, busy, done, pass, err_cnt, fail_vec
  );

endinterface

// File: rtl/cla_bist_ref.sv
// rtl/cla_bist_ref.sv - golden cla_4 model; g/p outputs exist only with CLA_BIST_GP_CHECK_EN.
module cla_bist_ref (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
`ifdef CLA_BIST_GP_CHECK_EN
  output logic       g_exp,
  output logic       p_exp,
`endif
  output logic [3:0] s_exp
);

  assign s_exp = a + b + {3'b000, c_in};

`ifdef CLA_BIST_GP_CHECK_EN
  // group generate ignores carry-in: it is the carry out of a+b alone
  assign g_exp = ({1'b0, a} + {1'b0, b}) >= 5'd16;
  assign p_exp = &(a ^ b);
`endif

endmodule

// File: rtl/cla_bist.sv
// rtl/cla_bist.sv - exhaustive 512-vector BIST sweep for cla_4; CLA_BIST_GP_CHECK_EN adds g/p compare.
module cla_bist
  import cla_bist_pkg::*;
#(
  parameter int SETTLE       = 1,
  parameter bit STOP_ON_FAIL = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  cla_bist_if.master bus
);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);

  state_t             state;
  state_t             state_nxt;
  logic [VEC_W-1:0]   vec;
  logic [CNT_W-1:0]   settle_cnt;
  logic               fail_seen;
  logic [ERR_W-1:0]   err_cnt;
  logic [VEC_W-1:0]   fail_vec;
  logic               busy;
  logic               done;
  logic               pass;

  logic [3:0]         s_exp;
  logic               mismatch;
  logic               settle_done;
  logic               stop_now;

  logic               accept;
  logic               settle_step;
  logic               compare;
  logic               advance;
  logic               finish;

  assign bus.a        = vec[8:5];
  assign bus.b        = vec[4:1];
  assign bus.c_in     = vec[0];
  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.pass     = pass;
  assign bus.err_cnt  = err_cnt;
  assign bus.fail_vec = fail_vec;

`ifdef CLA_BIST_GP_CHECK_EN
  logic g_exp;
  logic p_exp;

  cla_bist_ref u_ref (
    .a     (vec[8:5]),
    .b     (vec[4:1]),
    .c_in  (vec[0]),
    .g_exp (g_exp),
    .p_exp (p_exp),
    .s_exp (s_exp)
  );

  assign mismatch = (bus.s != s_exp) || (bus.g_out != g_exp) || (bus.p_out != p_exp);
`else
  cla_bist_ref u_ref (
    .a     (vec[8:5]),
    .b     (vec[4:1]),
    .c_in  (vec[0]),
    .s_exp (s_exp)
  );

  assign mismatch = (bus.s != s_exp);
`endif

  assign settle_done = (settle_cnt == SETTLE_LAST);
  assign stop_now    = (vec == LAST_VEC) || (STOP_ON_FAIL && mismatch);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (bus.start) state_nxt = DRIVE;
      DRIVE:      if (settle_done) state_nxt = SAMPLE;
      SAMPLE:     state_nxt = stop_now ? DONE : DRIVE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    accept      = 1'b0;
    settle_step = 1'b0;
    compare     = 1'b0;
    advance     = 1'b0;
    finish      = 1'b0;
    case (state)
      IDLE, DONE: accept      = bus.start;
      DRIVE:      settle_step = 1'b1;
      SAMPLE: begin
        compare = 1'b1;
        advance = !stop_now;
        finish  = stop_now;
      end
      default: ;
    endcase
  end

  // start while busy never reaches here: accept is only decoded in IDLE/DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec        <= '0;
      settle_cnt <= '0;
      fail_seen  <= 1'b0;
      err_cnt    <= '0;
      fail_vec   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
    end else if (accept) begin
      vec        <= '0;
      settle_cnt <= '0;
      fail_seen  <= 1'b0;
      err_cnt    <= '0;
      fail_vec   <= '0;
      busy       <= 1'b1;
      done       <= 1'b0;
      pass       <= 1'b0;
    end else begin
      if (settle_step) begin
        settle_cnt <= settle_done ? '0 : settle_cnt + CNT_W'(1);
      end
      if (compare && mismatch) begin
        err_cnt <= err_cnt + ERR_W'(1);
        if (!fail_seen) begin
          fail_vec  <= vec;
          fail_seen <= 1'b1;
        end
      end
      if (advance) begin
        vec <= vec + VEC_W'(1);
      end
      if (finish) begin
        busy <= 1'b0;
        done <= 1'b1;
        pass <= (err_cnt == '0) && !mismatch;
      end
    end
  end

endmodule
